// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encoding, default latency / address width, and the latency counter width.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_LATENCY = 2;
  localparam int DEF_ADDR_W  = 10;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage load/store bus between the requester (master) and the
// data-memory responder (slave), plus the responder's FSM state for observation.
interface data_mem_responder_if;
  import mem_resp_pkg::*;

  // Handshake: a request (Rd^Wr) is taken on a rising edge only while Stall
  // is low; the requester holds it for that one edge. Completion is the
  // single-cycle Done pulse; err pulses instead for an illegal request.
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;
  state_e      state;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Done, Stall, err, state
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Done, Stall, err, state
  );

endinterface

// File: rtl/mem_word_array.sv
// 2^ADDR_W x 16-bit word storage: synchronous write, asynchronous read, no reset.
module mem_word_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [15:0]       rd_data
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY cycles to
// a Done pulse. Define MEM_ALIGN_CHECK_EN to reject odd byte addresses via err.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [15:0]       data_out_q, data_out_d;
  logic              done_q, done_d;
  logic              stall_q, stall_d;
  logic              err_q, err_d;

  logic              sample, req, misalign, accept, illegal;
  logic              mem_we;
  logic [15:0]       mem_rdata, rd_word;
  logic              unused_addr;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = bus.Addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign unused_addr = ^{bus.Addr[15:ADDR_W+1], bus.Addr[0]};

  assign sample  = (state_q != BUSY);
  assign req     = bus.Rd ^ bus.Wr;
  assign accept  = sample && req && !misalign;
  assign illegal = sample && ((bus.Rd && bus.Wr) || (req && misalign));

  assign idx_d   = accept ? bus.Addr[ADDR_W:1] : idx_q;
  assign wdata_d = accept ? bus.DataIn : wdata_q;
  assign is_wr_d = accept ? bus.Wr : is_wr_q;

  // Pending write commits on the edge leaving DONE; a read landing in DONE on
  // that same edge (LATENCY=1 back-to-back) must see the new word.
  assign mem_we  = (state_q == DONE) && is_wr_q;
  assign rd_word = (mem_we && (idx_q == idx_d)) ? wdata_q : mem_rdata;

  mem_word_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .rd_idx  (idx_d),
    .rd_data (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    stall_d    = 1'b0;
    err_d      = illegal;
    data_out_d = data_out_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            stall_d = 1'b1;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == DONE && !is_wr_d) begin
      data_out_d = rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign bus.DataOut = data_out_q;
  assign bus.Done    = done_q;
  assign bus.Stall   = stall_q;
  assign bus.err     = err_q;
  assign bus.state   = state_q;

endmodule
